mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one single-ported, variable-latency memory bus between the instruction-fetch port (pc_reg/if_id side) and the data port (mem stage side) of the 5-stage core.
- Sequences one bus cycle at a time and gives data accesses priority.
- Holds each port's completed result until that pipeline stage advances, so a stalled stage is never re-fetched.
- Drives per-port stall requests into ctrl.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum cycles in BUSY without bus_ack_i before the cycle is forcibly terminated (minimum 2)

Ports:
- clk  in  1  clock; every register updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- inst_ce_i  in  1  fetch request
- inst_addr_i  in  ADDR_W  fetch address
- inst_data_o  out  DATA_W  fetched instruction (held buffer)
- stallreq_inst_o  out  1  fetch stall request to ctrl
- inst_adv_i  in  1  fetch stage advanced this cycle
- data_ce_i  in  1  data request
- data_we_i  in  1  1 = write
- data_sel_i  in  4  byte lanes
- data_addr_i  in  ADDR_W  data address
- data_data_i  in  DATA_W  write data
- data_data_o  out  DATA_W  read data (held buffer)
- stallreq_data_o  out  1  data stall request to ctrl
- data_adv_i  in  1  mem stage advanced this cycle
- flush_i  in  1  pipeline flush
- bus_stb_o  out  1  bus strobe
- bus_we_o  out  1  bus write enable
- bus_sel_o  out  4  bus byte lanes
- bus_addr_o  out  ADDR_W  bus address
- bus_wdata_o  out  DATA_W  bus write data
- bus_rdata_i  in  DATA_W  bus read data
- bus_ack_i  in  1  bus cycle complete
- bus_err_o  out  1  one-cycle timeout pulse
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; inst_done and data_done cleared; both buffers 0; all bus_* outputs 0; bus_err_o 0; timeout counter 0.
- Stall requests are combinational:
  - stallreq_inst_o = inst_ce_i & ~inst_done
  - stallreq_data_o = data_ce_i & ~data_done
- States: IDLE, BUSY.
- IDLE, one evaluation per cycle:
  - If data_ce_i & ~data_done: grant data.
  - Else if inst_ce_i & ~inst_done & ~flush_i: grant inst.
  - On a grant: register the granted port's bus fields, assert bus_stb_o the next cycle, enter BUSY, clear the counter, clear discard.
  - A fetch grant drives bus_we_o=0 and bus_sel_o=4'b1111.
- BUSY:
  - bus_* outputs are held stable.
  - The counter increments each cycle.
  - On bus_ack_i: latch bus_rdata_i into the granted port's buffer (writes latch nothing), set that port's done flag unless discard=1, drop bus_stb_o, and return to IDLE.
- Latency with a zero-wait slave:
  - request seen at cycle n;
  - stb asserted at n+1, ack at n+1;
  - done set and stall low at n+2.
- Back-to-back cycles: at least one IDLE cycle separates bus cycles.
- Timeout: if the counter reaches TIMEOUT-1 without an ack, treat the cycle as acked with rdata = 0 and pulse bus_err_o for 1 cycle.
- Done flags:
  - x_adv_i clears x_done.
  - flush_i clears both done flags.
  - Set and clear in the same cycle cannot occur legally; if it does, set wins.
- Flush while BUSY:
  - The bus cycle still completes, because the slave cannot be aborted.
  - discard=1, so the result is dropped and no done flag is set.
- Request inputs are sampled only at grant; changes during BUSY are ignored.
- inst_data_o and data_data_o always present their buffers; they change only on a latching ack.
- A reset mid-cycle returns to IDLE immediately with stb low; the in-flight ack is ignored.

Decomposition:
- Shared package:
  - state encoding (IDLE/BUSY);
  - grant encoding (GNT_INST=0, GNT_DATA=1);
  - ADDR_W/DATA_W defaults aligned with the existing InstAddrBus/DataBus defines;
  - ChipEnable/WriteEnable constants.
- One sub-module, bus_watchdog: the counter, clear/enable inputs, TIMEOUT parameter, expired output.

Test Plan:
- Fetch only: inst_ce=1, addr 0x100, ack on the first stb cycle with rdata 0x3401_0020 -> stb at n+1, stallreq_inst low at n+2, inst_data_o=0x3401_0020; inst_adv then clears done.
- Simultaneous requests: inst 0x104 and data read 0x2000 -> bus_addr_o=0x2000 first; after ack, one IDLE cycle, then 0x104.
- Fetch done while a data write (sel 4'b0011, 0xABCD) waits 5 cycles -> no second fetch of the same address; bus_we_o=1, bus_sel_o=0011; both stalls low only after the write ack.
- flush_i in BUSY during a fetch -> cycle completes, inst_done stays 0, inst_data_o unchanged, next request granted normally.
- TIMEOUT=4, no ack -> stb drops after 4 BUSY cycles, bus_err_o pulses once, data_data_o=0, stallreq_data drops.
- rst asserted in BUSY -> next cycle all outputs 0, state IDLE, late ack ignored.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory bus arbiter.
// Width defaults match the core's InstAddrBus/DataBus.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic       CHIP_ENABLE   = 1'b1;
    localparam logic       WRITE_DISABLE = 1'b0;
    localparam logic [3:0] SEL_ALL       = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } gnt_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Single-ported memory bus: the arbiter is the master, the memory is the slave.
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              bus_stb_o;
    logic              bus_we_o;
    logic [3:0]        bus_sel_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic [DATA_W-1:0] bus_rdata_i;
    logic              bus_ack_i;

    modport master (
        output bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        input  bus_rdata_i, bus_ack_i
    );

    modport slave (
        input  bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        output bus_rdata_i, bus_ack_i
    );
endinterface

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Cycle counter for an outstanding bus cycle; expired_o flags the last
// cycle the arbiter is allowed to wait for an ack.
module mem_bus_arbiter_bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int              CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CNT_TC);

    // Freeze at terminal count so power-of-two TIMEOUT values cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !expired_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one shared memory bus between instruction fetch and the mem stage,
// data first, one bus cycle at a time, holding results until the stage advances.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ce_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0] inst_data_o,
    output logic              stallreq_inst_o,
    input  logic              inst_adv_i,
    input  logic              data_ce_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_sel_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_data_i,
    output logic [DATA_W-1:0] data_data_o,
    output logic              stallreq_data_o,
    input  logic              data_adv_i,
    input  logic              flush_i,
    mem_bus_arbiter_if.master bus,
    output logic              bus_err_o,
    output logic              busy_o
);
    state_e            state_q, state_d;
    gnt_e              gnt_q, gnt_d;
    logic              discard_q, discard_d;
    logic              inst_done_q, inst_done_d;
    logic              data_done_q, data_done_d;
    logic [DATA_W-1:0] inst_buf_q, inst_buf_d;
    logic [DATA_W-1:0] data_buf_q, data_buf_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              wd_clr, wd_en, wd_expired;
    logic              data_req, inst_req;
    logic [DATA_W-1:0] rdata;

    mem_bus_arbiter_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    assign data_req = (data_ce_i == CHIP_ENABLE) && !data_done_q;
    assign inst_req = (inst_ce_i == CHIP_ENABLE) && !inst_done_q && !flush_i;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        discard_d   = discard_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        inst_buf_d  = inst_buf_q;
        data_buf_d  = data_buf_q;
        inst_done_d = inst_done_q;
        data_done_d = data_done_q;
        err_d       = 1'b0;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;
        rdata       = bus.bus_ack_i ? bus.bus_rdata_i : '0;

        if (inst_adv_i || flush_i) inst_done_d = 1'b0;
        if (data_adv_i || flush_i) data_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (data_req) begin
                    gnt_d   = GNT_DATA;
                    we_d    = data_we_i;
                    sel_d   = data_sel_i;
                    addr_d  = data_addr_i;
                    wdata_d = data_data_i;
                end else if (inst_req) begin
                    gnt_d   = GNT_INST;
                    we_d    = WRITE_DISABLE;
                    sel_d   = SEL_ALL;
                    addr_d  = inst_addr_i;
                    wdata_d = '0;
                end
                if (data_req || inst_req) begin
                    state_d   = ST_BUSY;
                    stb_d     = 1'b1;
                    wd_clr    = 1'b1;
                    discard_d = 1'b0;
                end
            end
            ST_BUSY: begin
                wd_en = 1'b1;
                if (flush_i) discard_d = 1'b1;
                // A timeout completes like an ack carrying zero data.
                if (bus.bus_ack_i || wd_expired) begin
                    state_d = ST_IDLE;
                    stb_d   = 1'b0;
                    err_d   = !bus.bus_ack_i;
                    if (!(discard_q || flush_i)) begin
                        if (gnt_q == GNT_DATA) begin
                            data_done_d = 1'b1;
                            if (!we_q) data_buf_d = rdata;
                        end else begin
                            inst_done_d = 1'b1;
                            inst_buf_d  = rdata;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_INST;
            discard_q   <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            inst_buf_q  <= '0;
            data_buf_q  <= '0;
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            discard_q   <= discard_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            inst_buf_q  <= inst_buf_d;
            data_buf_q  <= data_buf_d;
            inst_done_q <= inst_done_d;
            data_done_q <= data_done_d;
            err_q       <= err_d;
        end
    end

    assign bus.bus_stb_o   = stb_q;
    assign bus.bus_we_o    = we_q;
    assign bus.bus_sel_o   = sel_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_wdata_o = wdata_q;
    assign bus_err_o       = err_q;
    assign busy_o          = (state_q == ST_BUSY);
    assign inst_data_o     = inst_buf_q;
    assign data_data_o     = data_buf_q;
    assign stallreq_inst_o = inst_ce_i && !inst_done_q;
    assign stallreq_data_o = data_ce_i && !data_done_q;
endmodule
